// File: rtl/msxbus_pkg.sv
// Shared definitions for the MSX bus arbiter: command word layout, FSM states,
// timeout defaults and a helper that splits a command word into its fields.
package msxbus_pkg;

    localparam int CMD_W           = 27;
    localparam int CMD_MIO         = 26;
    localparam int CMD_RW          = 25;
    localparam int CMD_SLOT        = 24;
    localparam int CMD_ADDR_HI     = 23;
    localparam int CMD_ADDR_LO     = 8;
    localparam int CMD_WDATA_HI    = 7;

    localparam int TIMEOUT_DEFAULT = 1023;
    localparam int TW_DEFAULT      = 10;

    // Read data returned to the requester when the engine never answered.
    localparam logic [7:0] RDATA_TIMEOUT = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_DONE    = 2'd2,
        ST_RECOVER = 2'd3
    } msx_state_e;

    typedef struct packed {
        logic        mio;
        logic        rw;
        logic        slot;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } msx_cmd_t;

    function automatic msx_cmd_t cmd_unpack(input logic [CMD_W-1:0] cmd);
        msx_cmd_t c;
        c.mio   = cmd[CMD_MIO];
        c.rw    = cmd[CMD_RW];
        c.slot  = cmd[CMD_SLOT];
        c.addr  = cmd[CMD_ADDR_HI:CMD_ADDR_LO];
        c.wdata = cmd[CMD_WDATA_HI:0];
        return c;
    endfunction

endpackage

// File: rtl/msxbus_arbiter_wdog.sv
// Watchdog counter shared by the BUSY and RECOVER phases. Clear has priority,
// the count stops at the limit, and the terminal-count flag is registered so
// it is high exactly while the count equals LIMIT.
module msxbus_wdog #(
    parameter int TW    = 10,
    parameter int LIMIT = 1023
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [TW-1:0] LIMIT_C = TW'(LIMIT);
    localparam logic [TW-1:0] ONE_C   = {{(TW-1){1'b0}}, 1'b1};

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;
    logic          tc_q;

    // Next count: clear wins, otherwise advance while enabled and below the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = {TW{1'b0}};
        end else if (en && (cnt_q != LIMIT_C)) begin
            cnt_d = cnt_q + ONE_C;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count and terminal-count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {TW{1'b0}};
            tc_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= (cnt_d == LIMIT_C);
        end
    end

    assign tc = tc_q;

endmodule

// File: rtl/msxbus_arbiter.sv
// Two-port round-robin arbiter and sequencer in front of the MSX bus cycle
// engine. Latches the granted command, drives EN, waits for VAL_N or a
// timeout, returns data/error with a one-cycle ACK, then waits for the engine
// to release VAL_N before accepting the next request.
module msxbus_arbiter
    import msxbus_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int TW      = TW_DEFAULT
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ0,
    input  logic             REQ1,
    input  logic [CMD_W-1:0] CMD0,
    input  logic [CMD_W-1:0] CMD1,
    output logic             ACK0,
    output logic             ACK1,
    output logic [7:0]       RDATA,
    output logic             ERR,
    output logic             BUSY,
    output logic             EN,
    output logic [15:0]      ADDRESS,
    output logic             RW,
    output logic             MIO,
    output logic             SLOT,
    output logic [7:0]       WDATA,
    input  logic             VAL_N,
    input  logic [7:0]       ENG_RDATA
);

    localparam msx_cmd_t CMD_RESET = '{mio: 1'b0, rw: 1'b0, slot: 1'b0,
                                       addr: 16'h0000, wdata: 8'h00};

    msx_state_e state_q, state_d;
    logic       gnt_q, gnt_d;     // port owning the current transaction
    logic       last_q, last_d;   // port granted most recently
    logic       en_q, en_d;
    logic       busy_q, busy_d;
    logic       ack0_q, ack0_d;
    logic       ack1_q, ack1_d;
    logic [7:0] rdata_q, rdata_d;
    logic       err_q, err_d;
    msx_cmd_t   cmd_q, cmd_d;

    logic       sel_s;
    logic       wd_clr_s;
    logic       wd_en_s;
    logic       wd_tc_s;

    msxbus_wdog #(
        .TW    (TW),
        .LIMIT (TIMEOUT)
    ) u_wdog (
        .clk   (CLK),
        .rst_n (RST),
        .clr   (wd_clr_s),
        .en    (wd_en_s),
        .tc    (wd_tc_s)
    );

    // Round-robin pick, then next-state and output computation for the sequencer.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        last_d   = last_q;
        en_d     = en_q;
        busy_d   = busy_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        rdata_d  = rdata_q;
        err_d    = err_q;
        cmd_d    = cmd_q;
        wd_clr_s = 1'b0;
        wd_en_s  = 1'b0;
        sel_s    = 1'b0;

        // On a tie the port that did not win last time goes next.
        if (REQ0 && REQ1) begin
            sel_s = ~last_q;
        end else if (REQ1) begin
            sel_s = 1'b1;
        end else begin
            sel_s = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (REQ0 || REQ1) begin
                    gnt_d    = sel_s;
                    last_d   = sel_s;
                    cmd_d    = sel_s ? cmd_unpack(CMD1) : cmd_unpack(CMD0);
                    en_d     = 1'b1;
                    busy_d   = 1'b1;
                    wd_clr_s = 1'b1;
                    state_d  = ST_BUSY;
                end else begin
                    en_d     = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            ST_BUSY: begin
                wd_en_s = 1'b1;
                if (!VAL_N || wd_tc_s) begin
                    // Engine completion takes priority over a coincident timeout.
                    if (!VAL_N) begin
                        rdata_d = ENG_RDATA;
                        err_d   = 1'b0;
                    end else begin
                        rdata_d = RDATA_TIMEOUT;
                        err_d   = 1'b1;
                    end
                    ack0_d  = ~gnt_q;
                    ack1_d  = gnt_q;
                    en_d    = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    en_d    = 1'b1;
                    state_d = ST_BUSY;
                end
            end
            ST_DONE: begin
                en_d     = 1'b0;
                wd_clr_s = 1'b1;
                state_d  = ST_RECOVER;
            end
            ST_RECOVER: begin
                en_d    = 1'b0;
                wd_en_s = 1'b1;
                if (VAL_N || wd_tc_s) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RECOVER;
                end
            end
            default: begin
                en_d    = 1'b0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction without an ACK.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            rdata_q <= 8'h00;
            err_q   <= 1'b0;
            cmd_q   <= CMD_RESET;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cmd_q   <= cmd_d;
        end
    end

    assign ACK0    = ack0_q;
    assign ACK1    = ack1_q;
    assign RDATA   = rdata_q;
    assign ERR     = err_q;
    assign BUSY    = busy_q;
    assign EN      = en_q;
    assign ADDRESS = cmd_q.addr;
    assign RW      = cmd_q.rw;
    assign MIO     = cmd_q.mio;
    assign SLOT    = cmd_q.slot;
    assign WDATA   = cmd_q.wdata;

endmodule

// File: tb/tb_msxbus_arbiter.sv
// Table-driven bench for msxbus_arbiter with a small engine model and a
// scoreboard queue of expected completions, plus a hand-written reset sequence.
module tb_msxbus_arbiter;

    localparam int TO = 8;

    logic        CLK;
    logic        RST;
    logic        REQ0, REQ1;
    logic [26:0] CMD0, CMD1;
    logic        ACK0, ACK1;
    logic [7:0]  RDATA;
    logic        ERR, BUSY, EN;
    logic [15:0] ADDRESS;
    logic        RW, MIO, SLOT;
    logic [7:0]  WDATA;
    logic        VAL_N;
    logic [7:0]  ENG_RDATA;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        req0;
        logic        req1;
        logic [26:0] cmd0;
        logic [26:0] cmd1;
        int          val_at;    // BUSY cycle index where VAL_N goes low
        logic [7:0]  eng;
        bit          chg;       // scramble CMD0 right after grant
        int          rec_low;   // cycles VAL_N stays low after ACK
        bit          raise1;    // raise REQ1 while the engine still holds VAL_N
        int          exp_port;
        logic [7:0]  exp_rdata;
        logic        exp_err;
        int          exp_ack_i;
    } row_t;

    typedef struct {
        int         port;
        logic [7:0] rdata;
        logic       err;
        int         ack_i;
    } exp_t;

    exp_t sb[$];
    row_t rows[10];

    msxbus_arbiter #(.TIMEOUT(TO), .TW(10)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .REQ0      (REQ0),
        .REQ1      (REQ1),
        .CMD0      (CMD0),
        .CMD1      (CMD1),
        .ACK0      (ACK0),
        .ACK1      (ACK1),
        .RDATA     (RDATA),
        .ERR       (ERR),
        .BUSY      (BUSY),
        .EN        (EN),
        .ADDRESS   (ADDRESS),
        .RW        (RW),
        .MIO       (MIO),
        .SLOT      (SLOT),
        .WDATA     (WDATA),
        .VAL_N     (VAL_N),
        .ENG_RDATA (ENG_RDATA)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    function automatic logic [26:0] mk_cmd(input logic mio, input logic rw, input logic slot,
                                           input logic [15:0] a, input logic [7:0] d);
        return {mio, rw, slot, a, d};
    endfunction

    function automatic row_t mk_row(input logic r0, input logic r1,
                                    input logic [26:0] c0, input logic [26:0] c1,
                                    input int va, input logic [7:0] eng, input bit chg,
                                    input int rl, input bit rs1, input int ep,
                                    input logic [7:0] erd, input logic eer, input int eai);
        row_t r;
        r.req0 = r0; r.req1 = r1; r.cmd0 = c0; r.cmd1 = c1;
        r.val_at = va; r.eng = eng; r.chg = chg; r.rec_low = rl; r.raise1 = rs1;
        r.exp_port = ep; r.exp_rdata = erd; r.exp_err = eer; r.exp_ack_i = eai;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_row(input row_t r, input string nm);
        logic [26:0] ecmd;
        exp_t        e;
        exp_t        g;
        bit          got;
        int          ai;
        REQ0      = r.req0;
        REQ1      = r.req1;
        CMD0      = r.cmd0;
        CMD1      = r.cmd1;
        VAL_N     = 1'b1;
        ENG_RDATA = r.eng;
        got = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            if (EN) begin
                got = 1'b1;
                break;
            end
        end
        chk({nm, "_grant"}, {31'd0, got}, 32'd1);
        if (!got) return;
        ecmd = (r.exp_port == 1) ? r.cmd1 : r.cmd0;
        chk({nm, "_cmd_out"}, {5'd0, MIO, RW, SLOT, ADDRESS, WDATA}, {5'd0, ecmd});
        chk({nm, "_busy"}, {31'd0, BUSY}, 32'd1);
        e.port  = r.exp_port;
        e.rdata = r.exp_rdata;
        e.err   = r.exp_err;
        e.ack_i = r.exp_ack_i;
        sb.push_back(e);

        // Engine model: VAL_N low from BUSY cycle val_at onward until ACK.
        got = 1'b0;
        ai  = 0;
        for (int k = 0; k < TO + 6; k++) begin
            VAL_N = (k >= r.val_at) ? 1'b0 : 1'b1;
            if (r.chg && (k == 0)) CMD0 = r.cmd0 ^ 27'h0FFFFFF;
            @(negedge CLK);
            if (ACK0 || ACK1) begin
                got = 1'b1;
                ai  = k;
                break;
            end
        end
        chk({nm, "_ack_seen"}, {31'd0, got}, 32'd1);
        if (got) begin
            g = sb.pop_front();
            chk({nm, "_ack_port"}, {30'd0, ACK1, ACK0}, (g.port == 1) ? 32'd2 : 32'd1);
            chk({nm, "_rdata"}, {24'd0, RDATA}, {24'd0, g.rdata});
            chk({nm, "_err"}, {31'd0, ERR}, {31'd0, g.err});
            chk({nm, "_latency"}, ai, g.ack_i);
            chk({nm, "_done_en_busy"}, {30'd0, BUSY, EN}, 32'd2);
            chk({nm, "_cmd_held"}, {5'd0, MIO, RW, SLOT, ADDRESS, WDATA}, {5'd0, ecmd});
            if (g.port == 1) REQ1 = 1'b0;
            else             REQ0 = 1'b0;
        end else begin
            sb.delete();
        end

        // Recovery: ACK must be gone, EN low, BUSY held while VAL_N is low.
        for (int j = 0; j < ((r.rec_low > 0) ? r.rec_low : 1); j++) begin
            VAL_N = (j < r.rec_low) ? 1'b0 : 1'b1;
            if (r.raise1) REQ1 = 1'b1;
            @(negedge CLK);
            chk({nm, "_recover"}, {28'd0, ACK1, ACK0, BUSY, EN}, 32'd2);
        end
        VAL_N = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (!BUSY) begin
                got = 1'b1;
                break;
            end
            @(negedge CLK);
        end
        chk({nm, "_idle"}, {31'd0, got}, 32'd1);
    endtask

    initial begin
        bit got;
        rows[0] = mk_row(1'b1, 1'b1, mk_cmd(1'b0, 1'b0, 1'b0, 16'h1111, 8'h11),
                         mk_cmd(1'b1, 1'b1, 1'b1, 16'h2222, 8'h22),
                         1, 8'h31, 1'b0, 0, 1'b0, 0, 8'h31, 1'b0, 1);
        rows[1] = mk_row(1'b1, 1'b1, mk_cmd(1'b0, 1'b0, 1'b0, 16'h1111, 8'h11),
                         mk_cmd(1'b1, 1'b1, 1'b1, 16'h2222, 8'h22),
                         0, 8'h32, 1'b0, 0, 1'b0, 1, 8'h32, 1'b0, 0);
        rows[2] = mk_row(1'b1, 1'b1, mk_cmd(1'b0, 1'b0, 1'b0, 16'h1111, 8'h11),
                         mk_cmd(1'b1, 1'b1, 1'b1, 16'h2222, 8'h22),
                         3, 8'h33, 1'b0, 0, 1'b0, 0, 8'h33, 1'b0, 3);
        rows[3] = mk_row(1'b1, 1'b0, mk_cmd(1'b0, 1'b0, 1'b0, 16'h4000, 8'h00), 27'd0,
                         2, 8'hA5, 1'b0, 0, 1'b0, 0, 8'hA5, 1'b0, 2);
        rows[4] = mk_row(1'b0, 1'b1, 27'd0, mk_cmd(1'b1, 1'b1, 1'b0, 16'hBEEF, 8'h7E),
                         4, 8'h00, 1'b0, 0, 1'b0, 1, 8'h00, 1'b0, 4);
        rows[5] = mk_row(1'b0, 1'b1, 27'd0, mk_cmd(1'b0, 1'b0, 1'b1, 16'h8001, 8'h00),
                         100, 8'h3C, 1'b0, 0, 1'b0, 1, 8'hFF, 1'b1, TO);
        rows[6] = mk_row(1'b1, 1'b0, mk_cmd(1'b0, 1'b0, 1'b0, 16'h0200, 8'h00), 27'd0,
                         TO, 8'h5A, 1'b0, 0, 1'b0, 0, 8'h5A, 1'b0, TO);
        rows[7] = mk_row(1'b1, 1'b0, mk_cmd(1'b0, 1'b1, 1'b0, 16'hC0DE, 8'h99), 27'd0,
                         3, 8'h44, 1'b1, 4, 1'b1, 0, 8'h44, 1'b0, 3);
        rows[8] = mk_row(1'b0, 1'b1, 27'd0, mk_cmd(1'b1, 1'b0, 1'b0, 16'h00FE, 8'h00),
                         0, 8'hE7, 1'b0, 0, 1'b0, 1, 8'hE7, 1'b0, 0);
        rows[9] = mk_row(1'b1, 1'b1, mk_cmd(1'b0, 1'b0, 1'b1, 16'h1234, 8'h56),
                         mk_cmd(1'b1, 1'b0, 1'b0, 16'h9876, 8'h54),
                         1, 8'h69, 1'b0, 0, 1'b0, 0, 8'h69, 1'b0, 1);

        RST = 1'b0; REQ0 = 1'b0; REQ1 = 1'b0; CMD0 = 27'd0; CMD1 = 27'd0;
        VAL_N = 1'b1; ENG_RDATA = 8'h00;
        repeat (2) @(negedge CLK);
        chk("reset_flags", {24'd0, ACK1, ACK0, ERR, BUSY, EN, RW, MIO, SLOT}, 32'd0);
        chk("reset_rdata_addr_wdata", {RDATA, ADDRESS, WDATA}, 32'd0);
        RST = 1'b1;
        @(negedge CLK);

        for (int n = 0; n < 9; n++) begin
            run_row(rows[n], $sformatf("row%0d", n));
        end

        // Reset in the middle of a BUSY phase owned by port 0.
        REQ0 = 1'b1;
        REQ1 = 1'b0;
        CMD0 = mk_cmd(1'b1, 1'b1, 1'b1, 16'hFFFF, 8'hFF);
        got = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            if (EN) begin
                got = 1'b1;
                break;
            end
        end
        chk("rst_mid_grant", {31'd0, got}, 32'd1);
        repeat (2) @(negedge CLK);
        #2 RST = 1'b0;
        #1;
        chk("rst_mid_flags", {24'd0, ACK1, ACK0, ERR, BUSY, EN, RW, MIO, SLOT}, 32'd0);
        chk("rst_mid_rdata_addr_wdata", {RDATA, ADDRESS, WDATA}, 32'd0);
        REQ0 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            chk("rst_mid_no_ack", {30'd0, ACK1, ACK0}, 32'd0);
        end
        RST = 1'b1;
        @(negedge CLK);
        run_row(rows[9], "row9_tie_after_reset");

        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/msxbus_arbiter.md
# msxbus_arbiter

Two-port arbiter and sequencer for the single MSX bus cycle engine (MSXBUS).
- Accepts bus-cycle commands from two requesters (port 0: host MD interface, port 1: auxiliary/DMA) and grants them round-robin.
- Drives the engine's EN/command inputs and waits for completion.
- Returns read data and a timeout error to the granted requester.
- Sits between the host-side mode decoder and MSXBUS, replacing direct EN/ADDRESS wiring.

## Interface
- TIMEOUT, default 1023: max BUSY cycles before a forced abort; range 1..2^TW-1.
- TW, default 10: width of the timeout counter.
- CLK  in  1: system clock; all state changes on its rising edge.
- RST  in  1: reset, asynchronous and active-low.
- REQ0, REQ1  in  1: request level. Held high until the matching ACK, then low in the next cycle.
- CMD0, CMD1  in  27: command word.
  - [26] MIO: 0 = memory, 1 = I/O.
  - [25] RW: 1 = write.
  - [24] SLOT.
  - [23:8] ADDRESS.
  - [7:0] WDATA.
- ACK0, ACK1  out  1: one-cycle completion pulse to the granted port.
- RDATA  out  8: read data, valid only while an ACK is high.
- ERR  out  1: timeout flag, valid only while an ACK is high.
- BUSY  out  1: high from grant until return to IDLE.
- EN  out  1: engine enable.
- ADDRESS  out  16, RW  out  1, MIO  out  1, SLOT  out  1, WDATA  out  8: registered command fields to the engine.
- VAL_N  in  1: engine completion, active-low. Returns high once EN has been low for at least one cycle.
- ENG_RDATA  in  8: engine read data, sampled when VAL_N is low.

## Operation
- States: IDLE, BUSY, DONE, RECOVER. Encoding lives in the package.
- IDLE
  - If exactly one REQ is high, grant it.
  - If both are high, grant the port other than LAST (round-robin pointer). LAST resets to 1, so port 0 wins the first tie.
  - On grant: latch that CMD into the engine output registers, set EN=1, clear the counter, record GNT, update LAST, go to BUSY.
  - With no REQ, stay in IDLE with EN=0.
- BUSY
  - Counter increments each cycle.
  - VAL_N=0: latch ENG_RDATA into RDATA (writes also latch it; the value is don't-care), set ERR=0, go to DONE.
  - Counter reaches TIMEOUT with VAL_N still high: RDATA=8'hFF, ERR=1, go to DONE.
  - If VAL_N=0 and the timeout occur in the same cycle, completion wins (ERR=0).
- DONE
  - ACKx=1 for the granted port only, EN=0. Always exactly one cycle.
  - Next state is RECOVER.
- RECOVER
  - EN=0, REQs ignored. Counter is re-cleared on entry.
  - Go to IDLE when VAL_N=1. If VAL_N stays low for TIMEOUT cycles, go to IDLE anyway.
  - Minimum one cycle in this state.
- CMD changes after grant are ignored; the command is latched once per transaction.
- A REQ deasserted before its ACK is a protocol violation. The transaction still completes and still pulses ACK.
- Reset values: EN=0, ACK0=ACK1=0, RDATA=8'h00, ERR=0, BUSY=0, ADDRESS=16'h0000, RW=0, MIO=0, SLOT=0, WDATA=8'h00, state=IDLE, LAST=1.
- Reset asserted mid-transaction: all outputs return to reset values immediately, and no ACK is issued for the aborted request.

## Timing
- A REQ sampled at edge 0 in IDLE gives EN and command outputs valid from edge 0 onward (registered).
- VAL_N first sampled low at edge k gives ACK high for cycle k..k+1. Request-to-ACK latency is therefore k+1 edges, minimum 2.
- Back-to-back throughput: at least 4 cycles per transaction (BUSY≥1, DONE 1, RECOVER≥1, IDLE 1).
- Timeout ACK arrives exactly TIMEOUT+1 edges after grant.
- BUSY and EN are glitch-free register outputs. ACKx never overlap.

## Structure
- Shared package msxbus_pkg holds:
  - CMD bit offsets (CMD_MIO=26, CMD_RW=25, CMD_SLOT=24, CMD_ADDR_HI=23, CMD_ADDR_LO=8).
  - The state enum.
  - RDATA_TIMEOUT=8'hFF.
  - TIMEOUT default.
- One sub-module, msxbus_wdog: TW-bit counter with clear, enable and a terminal-count flag. Used in both BUSY and RECOVER.
- Round-robin selection stays inline; it is two-way only.

## Test plan
- Single read: REQ0 with CMD0 = MIO=0, RW=0, ADDR=16'h4000. Engine returns ENG_RDATA=8'hA5 with VAL_N low 3 cycles after EN. Expect ACK0 pulse, RDATA=8'hA5, ERR=0, ADDRESS=16'h4000 throughout BUSY.
- Simultaneous REQ0 and REQ1 from reset, both held. Expect grant order 0, 1, 0 with ACK0, ACK1, ACK0, and no overlapping EN periods.
- Timeout: TIMEOUT=8, VAL_N held high. Expect ACK1 nine edges after grant, RDATA=8'hFF, ERR=1, then IDLE after VAL_N goes high.
- Completion and timeout in the same cycle: VAL_N low exactly at count 8. Expect ERR=0 and RDATA=ENG_RDATA.
- Reset mid-BUSY: assert RST 2 cycles after grant. Expect EN=0 and all outputs at reset values asynchronously, no ACK, and port 0 wins the next tie.
- CMD0 altered during BUSY: expect ADDRESS/WDATA unchanged until DONE. RECOVER holds while VAL_N stays low, and the next REQ waits until VAL_N=1.
